exmem_skid: RTL and testbench

Pipeline boundary between the execute stage (ALU) and the memory stage. Captures the ALU result, its overflow flag and the store/writeback control bundle of one instruction per cycle. A two-entry skid buffer with a valid/ready handshake on both sides lets the memory stage stall without a combinational ready path back into execute. Arithmetic overflow on trapping instructions becomes a precise exception tag here, so the memory stage never commits a bad write.

---
 rtl/exmem_skid_pkg.sv | 47 ++++
 rtl/exmem_skid_entry.sv | 36 +++
 rtl/exmem_skid.sv | 106 ++++++++++
 tb/tb_exmem_skid.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exmem_skid_pkg.sv
// Shared widths and control-bundle bit layout for the EX/MEM boundary.
// The memory stage imports this package to decode the same layout.
package exmem_skid_pkg;

  localparam int N      = 32;  // datapath width: ALU result, store data, PC
  localparam int REG_W  = 5;   // register number width
  localparam int CTRL_W = 5;   // control bundle width

  // Bit positions inside the control bundle
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_EXC_OVF    = 4;

  typedef struct packed {
    logic [N-1:0]      alu_out;
    logic [N-1:0]      store_data;
    logic [N-1:0]      pc;
    logic [REG_W-1:0]  dst_reg;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;

  // Build the stored control bundle. A trapping overflow becomes a precise
  // exception tag and suppresses every architectural side effect, so the
  // memory stage cannot commit a bad write.
  function automatic logic [CTRL_W-1:0] pack_ctrl(
    input logic overflow,
    input logic trap_en,
    input logic reg_write,
    input logic mem_to_reg,
    input logic mem_read,
    input logic mem_write
  );
    logic              exc;
    logic [CTRL_W-1:0] c;
    exc = overflow & trap_en;
    c = '0;
    c[CTRL_REG_WRITE]  = reg_write & ~exc;
    c[CTRL_MEM_TO_REG] = mem_to_reg;
    c[CTRL_MEM_READ]   = mem_read & ~exc;
    c[CTRL_MEM_WRITE]  = mem_write & ~exc;
    c[CTRL_EXC_OVF]    = exc;
    return c;
  endfunction

endpackage

// File: rtl/exmem_skid_entry.sv
// One buffer slot: a valid bit plus a payload register.
// Payload loads only on its enable and is otherwise held (never zeroed
// except by reset); clear has priority over load for the valid bit.
module exmem_entry
  import exmem_skid_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     load,
  input  logic     clear,
  input  payload_t d,
  output logic     valid,
  output payload_t q
);

  // Valid flag: set on load, dropped on clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload register with load enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/exmem_skid.sv
// EX/MEM pipeline boundary: two-entry skid buffer (main + skid) with a
// registered ex_ready, so there is no combinational mem_ready -> ex_ready path.
// Main always holds the older instruction; skid only fills when main is
// stalled and drains into main on the next consume.
module exmem_skid
  import exmem_skid_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [N-1:0]     ex_alu_out,
  input  logic             ex_overflow,
  input  logic             ex_trap_en,
  input  logic [N-1:0]     ex_store_data,
  input  logic [REG_W-1:0] ex_dst_reg,
  input  logic [N-1:0]     ex_pc,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic             flush,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [N-1:0]     mem_alu_out,
  output logic [N-1:0]     mem_store_data,
  output logic [N-1:0]     mem_pc,
  output logic [REG_W-1:0] mem_dst_reg,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             mem_reg_write,
  output logic             mem_mem_to_reg,
  output logic             mem_exc_ovf
);

  payload_t in_payload;
  payload_t main_d;
  payload_t main_q;
  payload_t skid_q;
  logic     main_valid;
  logic     skid_valid;
  logic     accept;
  logic     consume;
  logic     skid_to_main;
  logic     main_load;
  logic     main_clear;
  logic     skid_load;
  logic     skid_clear;

  // Incoming payload with the exception tag applied at load time
  always_comb begin
    in_payload.alu_out    = ex_alu_out;
    in_payload.store_data = ex_store_data;
    in_payload.pc         = ex_pc;
    in_payload.dst_reg    = ex_dst_reg;
    in_payload.ctrl       = pack_ctrl(ex_overflow, ex_trap_en, ex_reg_write,
                                      ex_mem_to_reg, ex_mem_read, ex_mem_write);
  end

  // Handshake and entry steering; flush suppresses every load so an
  // accept in the same cycle is discarded.
  always_comb begin
    accept       = ex_valid && ex_ready;
    consume      = main_valid && mem_ready;
    skid_to_main = skid_valid && consume;
    main_load    = !flush && (skid_to_main || (accept && (!main_valid || consume)));
    main_clear   = flush || (consume && !main_load);
    skid_load    = !flush && accept && main_valid && !consume;
    skid_clear   = flush || skid_to_main;
    main_d       = skid_to_main ? skid_q : in_payload;
  end

  exmem_entry u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (main_load),
    .clear   (main_clear),
    .d       (main_d),
    .valid   (main_valid),
    .q       (main_q)
  );

  exmem_entry u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .d       (in_payload),
    .valid   (skid_valid),
    .q       (skid_q)
  );

  // skid_valid is a flop, so ex_ready is a registered signal
  assign ex_ready       = !skid_valid;
  assign mem_valid      = main_valid;
  assign mem_alu_out    = main_q.alu_out;
  assign mem_store_data = main_q.store_data;
  assign mem_pc         = main_q.pc;
  assign mem_dst_reg    = main_q.dst_reg;
  assign mem_reg_write  = main_q.ctrl[CTRL_REG_WRITE];
  assign mem_mem_to_reg = main_q.ctrl[CTRL_MEM_TO_REG];
  assign mem_mem_read   = main_q.ctrl[CTRL_MEM_READ];
  assign mem_mem_write  = main_q.ctrl[CTRL_MEM_WRITE];
  assign mem_exc_ovf    = main_q.ctrl[CTRL_EXC_OVF];

endmodule

// File: tb/tb_exmem_skid.sv
// Scoreboard bench for exmem_skid: every accepted instruction is pushed with
// its expected tagged payload and popped/compared when the memory stage consumes.
module tb_exmem_skid;
  import exmem_skid_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             ex_valid = 1'b0;
  logic             ex_ready;
  logic [N-1:0]     ex_alu_out = '0;
  logic             ex_overflow = 1'b0;
  logic             ex_trap_en = 1'b0;
  logic [N-1:0]     ex_store_data = '0;
  logic [REG_W-1:0] ex_dst_reg = '0;
  logic [N-1:0]     ex_pc = '0;
  logic             ex_mem_read = 1'b0;
  logic             ex_mem_write = 1'b0;
  logic             ex_reg_write = 1'b0;
  logic             ex_mem_to_reg = 1'b0;
  logic             flush = 1'b0;
  logic             mem_valid;
  logic             mem_ready = 1'b0;
  logic [N-1:0]     mem_alu_out;
  logic [N-1:0]     mem_store_data;
  logic [N-1:0]     mem_pc;
  logic [REG_W-1:0] mem_dst_reg;
  logic             mem_mem_read;
  logic             mem_mem_write;
  logic             mem_reg_write;
  logic             mem_mem_to_reg;
  logic             mem_exc_ovf;

  int checks = 0;
  int errors = 0;
  payload_t exp_q[$];
  payload_t obs;
  payload_t cur_exp;

  exmem_skid dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_alu_out     (ex_alu_out),
    .ex_overflow    (ex_overflow),
    .ex_trap_en     (ex_trap_en),
    .ex_store_data  (ex_store_data),
    .ex_dst_reg     (ex_dst_reg),
    .ex_pc          (ex_pc),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_alu_out    (mem_alu_out),
    .mem_store_data (mem_store_data),
    .mem_pc         (mem_pc),
    .mem_dst_reg    (mem_dst_reg),
    .mem_mem_read   (mem_mem_read),
    .mem_mem_write  (mem_mem_write),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_exc_ovf    (mem_exc_ovf)
  );

  always #5 clk = ~clk;

  // Observed main-entry payload in scoreboard layout
  always_comb begin
    obs.alu_out    = mem_alu_out;
    obs.store_data = mem_store_data;
    obs.pc         = mem_pc;
    obs.dst_reg    = mem_dst_reg;
    obs.ctrl       = '0;
    obs.ctrl[CTRL_REG_WRITE]  = mem_reg_write;
    obs.ctrl[CTRL_MEM_TO_REG] = mem_mem_to_reg;
    obs.ctrl[CTRL_MEM_READ]   = mem_mem_read;
    obs.ctrl[CTRL_MEM_WRITE]  = mem_mem_write;
    obs.ctrl[CTRL_EXC_OVF]    = mem_exc_ovf;
  end

  // Expected stored payload for the instruction currently offered
  always_comb begin
    logic exc;
    exc = ex_overflow && ex_trap_en;
    cur_exp.alu_out    = ex_alu_out;
    cur_exp.store_data = ex_store_data;
    cur_exp.pc         = ex_pc;
    cur_exp.dst_reg    = ex_dst_reg;
    cur_exp.ctrl       = '0;
    cur_exp.ctrl[CTRL_REG_WRITE]  = exc ? 1'b0 : ex_reg_write;
    cur_exp.ctrl[CTRL_MEM_TO_REG] = ex_mem_to_reg;
    cur_exp.ctrl[CTRL_MEM_READ]   = exc ? 1'b0 : ex_mem_read;
    cur_exp.ctrl[CTRL_MEM_WRITE]  = exc ? 1'b0 : ex_mem_write;
    cur_exp.ctrl[CTRL_EXC_OVF]    = exc;
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic v, input logic [N-1:0] alu, input logic ovf,
                       input logic trap, input logic rw);
    ex_valid      = v;
    ex_alu_out    = alu;
    ex_overflow   = ovf;
    ex_trap_en    = trap;
    ex_reg_write  = rw;
    ex_store_data = $urandom;
    ex_pc         = $urandom;
    ex_dst_reg    = REG_W'($urandom_range(0, 31));
    ex_mem_read   = 1'($urandom_range(0, 1));
    ex_mem_write  = 1'($urandom_range(0, 1));
    ex_mem_to_reg = 1'($urandom_range(0, 1));
  endtask

  // One clock: score the handshakes that the next rising edge will perform
  task automatic step();
    payload_t e;
    @(negedge clk);
    if (mem_valid && mem_ready) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("payload", obs, e);
        $display("consume alu=%08h pc=%08h exc=%0b", mem_alu_out, mem_pc, mem_exc_ovf);
      end
    end
    if (flush) exp_q.delete();
    else if (ex_valid && ex_ready) exp_q.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_mem_valid", mem_valid, 0);
    check_val("rst_ex_ready", ex_ready, 1);
    check_val("rst_alu_out", mem_alu_out, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming: one-cycle latency, ex_ready stays high
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b1);
      if (i > 0) begin
        check_val("stream_ex_ready", ex_ready, 1);
        check_val("stream_mem_valid", mem_valid, 1);
        check_val("stream_latency", mem_alu_out, 32'h100 + 32'(i - 1));
      end
      step();
    end
    offer(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_val("stream_last", mem_alu_out, 32'h107);
    step();
    check_val("stream_empty", mem_valid, 0);

    // Stall absorb: A in main, B in skid, then release in order
    mem_ready = 1'b0;
    offer(1'b1, 32'hA0, 1'b0, 1'b0, 1'b1);
    step();
    offer(1'b1, 32'hB0, 1'b0, 1'b0, 1'b1);
    step();
    check_val("stall_ex_ready", ex_ready, 0);
    check_val("stall_main", mem_alu_out, 32'hA0);
    offer(1'b0, '0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b1;
    step();
    check_val("release_b", mem_alu_out, 32'hB0);
    check_val("release_valid", mem_valid, 1);
    check_val("release_ex_ready", ex_ready, 1);
    step();
    check_val("release_empty", mem_valid, 0);

    // Overflow trap tagging
    offer(1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    step();
    check_val("trap_exc", mem_exc_ovf, 1);
    check_val("trap_rw", mem_reg_write, 0);
    check_val("trap_mw", mem_mem_write, 0);
    check_val("trap_alu", mem_alu_out, 32'h8000_0000);
    offer(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    step();
    check_val("notrap_exc", mem_exc_ovf, 0);
    check_val("notrap_rw", mem_reg_write, 1);
    offer(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();

    // Flush with both entries full and an instruction offered
    mem_ready = 1'b0;
    offer(1'b1, 32'hC1, 1'b0, 1'b0, 1'b1);
    step();
    offer(1'b1, 32'hC2, 1'b0, 1'b0, 1'b1);
    step();
    offer(1'b1, 32'hC3, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("flush_full_valid", mem_valid, 0);
    check_val("flush_full_ready", ex_ready, 1);
    // Flush while an accept actually happens: that accept is discarded
    offer(1'b1, 32'hD1, 1'b0, 1'b0, 1'b1);
    step();
    offer(1'b1, 32'hD2, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("flush_acc_valid", mem_valid, 0);
    check_val("flush_acc_ready", ex_ready, 1);
    offer(1'b0, '0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b1;
    step();
    step();
    check_val("flush_nothing", mem_valid, 0);

    // Async reset in the middle of a stall with skid full
    mem_ready = 1'b0;
    offer(1'b1, 32'hE1, 1'b0, 1'b0, 1'b1);
    step();
    offer(1'b1, 32'hE2, 1'b0, 1'b0, 1'b1);
    step();
    offer(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_val("pre_rst_ready", ex_ready, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("arst_valid", mem_valid, 0);
    check_val("arst_alu", mem_alu_out, 0);
    check_val("arst_ready", ex_ready, 1);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Random valid/ready with occasional flush against the FIFO model
    for (int i = 0; i < 10000; i++) begin
      offer(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      mem_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 63) == 0);
      step();
    end
    flush = 1'b0;
    offer(1'b0, '0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check_val("drain_queue", 128'(exp_q.size()), 0);
    check_val("drain_valid", mem_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
